// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA decryption datapath front end
// (r_t_gen, n0prime and the secondary-input controller).
package rsa_pkg;

    // Default modulus / result width shared across the datapath.
    localparam int N_WIDTH = 1024;

    // Edges from the accepted start to the cycle where done is high, n >= 2.
    localparam int R_T_LATENCY = 2 * N_WIDTH + 1;

    // Control states of the r/t constant generator.
    typedef enum logic [1:0] {
        IDLE,
        CALC_R,
        CALC_T,
        ERR
    } r_t_state_e;

    // Start-to-done latency for an arbitrary width.
    function automatic int r_t_latency(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/r_t_gen_mod_double.sv
// Modular doubling: y = (2x >= n) ? 2x - n : 2x, valid while x < n.
// Kept as its own module so the wide compare/subtract can be timed in isolation.
module mod_double #(
    parameter int N_WIDTH = rsa_pkg::N_WIDTH
) (
    input  logic [N_WIDTH-1:0] x,
    input  logic [N_WIDTH-1:0] n,
    output logic [N_WIDTH-1:0] y
);
    import rsa_pkg::*;

    logic [N_WIDTH:0] dbl;
    logic [N_WIDTH:0] nn;
    logic [N_WIDTH:0] diff;

    // One-bit-wider double, single conditional subtract, truncate to N bits.
    always_comb begin
        dbl  = {x, 1'b0};
        nn   = {1'b0, n};
        diff = dbl - nn;
        y    = N_WIDTH'((dbl >= nn) ? diff : dbl);
    end

endmodule

// File: rtl/r_t_gen.sv
// Montgomery constant generator: r = 2^N mod n, t = 2^(2N) mod n.
// Responds to a one-cycle start with a one-cycle done after 2N doublings.
module r_t_gen #(
    parameter int N_WIDTH = rsa_pkg::N_WIDTH,
    parameter int CNT_W   = $clog2(N_WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_WIDTH-1:0] n,
    output logic [N_WIDTH-1:0] r,
    output logic [N_WIDTH-1:0] t,
    output logic               done,
    output logic               busy,
    output logic               err
);
    import rsa_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WIDTH - 1);

    r_t_state_e         state, state_nx;
    logic [N_WIDTH-1:0] x, x_nx;
    logic [N_WIDTH-1:0] n_q, n_q_nx;
    logic [N_WIDTH-1:0] x_dbl;
    logic [N_WIDTH-1:0] r_nx, t_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               done_nx, busy_nx, err_nx;

    // Single doubler shared by the r and t phases; x keeps doubling across both.
    mod_double #(.N_WIDTH(N_WIDTH)) u_mod_double (
        .x (x),
        .n (n_q),
        .y (x_dbl)
    );

    // State and datapath registers; rst aborts any computation at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            n_q   <= '0;
            cnt   <= '0;
            r     <= '0;
            t     <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            x     <= x_nx;
            n_q   <= n_q_nx;
            cnt   <= cnt_nx;
            r     <= r_nx;
            t     <= t_nx;
            done  <= done_nx;
            busy  <= busy_nx;
            err   <= err_nx;
        end
    end

    // Next-state and register updates for the start/done handshake.
    always_comb begin
        state_nx = state;
        x_nx     = x;
        n_q_nx   = n_q;
        cnt_nx   = cnt;
        r_nx     = r;
        t_nx     = t;
        done_nx  = 1'b0;
        busy_nx  = busy;
        err_nx   = err;

        case (state)
            IDLE: begin
                if (start) begin
                    if (n >= N_WIDTH'(2)) begin
                        n_q_nx   = n;
                        x_nx     = N_WIDTH'(1);
                        cnt_nx   = '0;
                        err_nx   = 1'b0;
                        busy_nx  = 1'b1;
                        state_nx = CALC_R;
                    end else begin
                        r_nx     = '0;
                        t_nx     = '0;
                        err_nx   = 1'b1;
                        state_nx = ERR;
                    end
                end
            end
            CALC_R: begin
                x_nx   = x_dbl;
                cnt_nx = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    r_nx     = x_dbl;
                    cnt_nx   = '0;
                    state_nx = CALC_T;
                end
            end
            CALC_T: begin
                x_nx   = x_dbl;
                cnt_nx = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    t_nx     = x_dbl;
                    cnt_nx   = '0;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            ERR: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_r_t_gen.sv
// Bench for r_t_gen: an 8-bit instance checked every cycle against an
// event-scheduled reference model, plus a 1024-bit instance checked per run
// against wide-arithmetic reference values.
module tb_r_t_gen;
    localparam int NS = 8;
    localparam int NL = 1024;
    localparam int unsigned NONE = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst8, start8;
    logic [NS-1:0] n8, r8, t8;
    logic          done8, busy8, err8;

    logic          rstl, startl;
    logic [NL-1:0] nl, rl, tl;
    logic          donel, busyl, errl;

    int n_tests = 0;
    int n_fail  = 0;

    r_t_gen #(.N_WIDTH(NS)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .n(n8),
        .r(r8), .t(t8), .done(done8), .busy(busy8), .err(err8)
    );

    r_t_gen #(.N_WIDTH(NL)) dutl (
        .clk(clk), .rst(rstl), .start(startl), .n(nl),
        .r(rl), .t(tl), .done(donel), .busy(busyl), .err(errl)
    );

    // Reference model for the 8-bit instance: schedules future output events
    // from the edge number at which a request is accepted.
    int unsigned   e8        = 0;
    int unsigned   free_at   = 0;
    int unsigned   done_edge = NONE;
    int unsigned   r_edge    = NONE;
    int unsigned   t_edge    = NONE;
    logic [NS-1:0] r_pend = '0, t_pend = '0, r_m = '0, t_m = '0;
    logic          done_m = 1'b0, busy_m = 1'b0, err_m = 1'b0;

    always @(posedge clk or posedge rst8) begin : model8
        int unsigned e;
        if (rst8) begin
            busy_m    <= 1'b0;
            done_m    <= 1'b0;
            err_m     <= 1'b0;
            r_m       <= '0;
            t_m       <= '0;
            free_at   <= 0;
            done_edge <= NONE;
            r_edge    <= NONE;
            t_edge    <= NONE;
        end else begin
            e = e8 + 1;
            e8     <= e;
            done_m <= (e == done_edge);
            if (e == r_edge) r_m <= r_pend;
            if (e == t_edge) t_m <= t_pend;
            if (e == done_edge) busy_m <= 1'b0;
            if (e >= free_at && start8) begin
                if (n8 >= 8'd2) begin
                    r_pend    <= NS'(256 % int'(n8));
                    t_pend    <= NS'(65536 % int'(n8));
                    r_edge    <= e + NS;
                    t_edge    <= e + 2 * NS;
                    done_edge <= e + 2 * NS;
                    free_at   <= e + 2 * NS + 1;
                    busy_m    <= 1'b1;
                    err_m     <= 1'b0;
                end else begin
                    r_m       <= '0;
                    t_m       <= '0;
                    err_m     <= 1'b1;
                    done_edge <= e + 1;
                    free_at   <= e + 2;
                    r_edge    <= NONE;
                    t_edge    <= NONE;
                end
            end
        end
    end

    // Every-cycle comparison of the 8-bit instance against the model.
    always @(negedge clk) begin
        n_tests++;
        if (r8 !== r_m || t8 !== t_m || done8 !== done_m || busy8 !== busy_m || err8 !== err_m) begin
            n_fail++;
            $display("FAIL model8 @%0t got r=%0d t=%0d done=%b busy=%b err=%b want r=%0d t=%0d done=%b busy=%b err=%b",
                     $time, r8, t8, done8, busy8, err8, r_m, t_m, done_m, busy_m, err_m);
        end
    end

    task automatic chk(input string nm, input logic [NL-1:0] got, input logic [NL-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got[63:0]=%0h want[63:0]=%0h", nm, got[63:0], exp[63:0]);
        end
    endtask

    // Called at a negedge; issues start and waits (bounded) for done.
    task automatic run8(input logic [NS-1:0] nv, input logic [NS-1:0] er, input logic [NS-1:0] et,
                        input logic ee, input int lat, input int bcyc, input bit scramble, input string nm);
        int edges;
        int bc;
        start8 = 1'b1;
        n8     = nv;
        @(posedge clk);
        edges = 1;
        bc    = 0;
        @(negedge clk);
        start8 = 1'b0;
        while (!done8 && edges < 200) begin
            if (busy8) bc++;
            if (scramble) begin
                n8     = NS'($urandom);
                start8 = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start8 = 1'b0;
        chk({nm, "_latency"}, NL'(edges), NL'(lat));
        chk({nm, "_busy_cycles"}, NL'(bc), NL'(bcyc));
        chk({nm, "_r"}, NL'(r8), NL'(er));
        chk({nm, "_t"}, NL'(t8), NL'(et));
        chk({nm, "_err"}, NL'(err8), NL'(ee));
    endtask

    task automatic runl(input logic [NL-1:0] nv, input bit use_lit, input logic [NL-1:0] lit_rt,
                        input bit extra, input string nm);
        logic [NL:0]     p;
        logic [2*NL-1:0] sq;
        logic [NL-1:0]   rr, tt;
        int              edges;
        p      = '0;
        p[NL]  = 1'b1;
        rr     = NL'(p % {1'b0, nv});
        sq     = {{NL{1'b0}}, rr} * {{NL{1'b0}}, rr};
        tt     = NL'(sq % {{NL{1'b0}}, nv});
        if (use_lit) begin
            rr = lit_rt;
            tt = lit_rt;
        end
        @(negedge clk);
        startl = 1'b1;
        nl     = nv;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        startl = 1'b0;
        while (!donel && edges < 2300) begin
            if (extra && (edges % 300 == 7)) begin
                startl = 1'b1;
                nl     = ~nv;
            end else begin
                startl = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        startl = 1'b0;
        chk({nm, "_latency"}, NL'(edges), NL'(2 * NL + 1));
        chk({nm, "_r"}, rl, rr);
        chk({nm, "_t"}, tl, tt);
        chk({nm, "_err"}, NL'(errl), '0);
        chk({nm, "_busy_after"}, NL'(busyl), '0);
    endtask

    initial begin
        logic [NL-1:0] nv;
        bit            saw;

        rst8 = 1'b1; start8 = 1'b0; n8 = '0;
        rstl = 1'b1; startl = 1'b0; nl = '0;
        repeat (3) @(negedge clk);
        chk("reset_r8", NL'(r8), '0);
        chk("reset_flags8", NL'({done8, busy8, err8}), '0);
        chk("reset_rl", rl, '0);
        chk("reset_flagsl", NL'({donel, busyl, errl}), '0);
        rst8 = 1'b0;
        rstl = 1'b0;
        @(negedge clk);

        // Directed 8-bit cases with hand-computed expectations.
        run8(8'd13,  8'd9, 8'd3,  1'b0, 17, 16, 1'b0, "n13");
        run8(8'd251, 8'd5, 8'd25, 1'b0, 17, 16, 1'b0, "n251");
        run8(8'd255, 8'd1, 8'd1,  1'b0, 17, 16, 1'b0, "n255_b2b");
        run8(8'd1,   8'd0, 8'd0,  1'b1, 2,  0,  1'b0, "n1_err");
        run8(8'd0,   8'd0, 8'd0,  1'b1, 2,  0,  1'b0, "n0_err");
        @(negedge clk);
        run8(8'd13,  8'd9, 8'd3,  1'b0, 17, 16, 1'b1, "n13_scramble");

        // Abort mid-computation with an asynchronous reset.
        @(negedge clk);
        start8 = 1'b1; n8 = 8'd251;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst8 = 1'b1;
        #1;
        chk("abort_r", NL'(r8), '0);
        chk("abort_t", NL'(t8), '0);
        chk("abort_flags", NL'({done8, busy8, err8}), '0);
        @(negedge clk);
        rst8 = 1'b0;
        saw = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done8) saw = 1'b1;
        end
        chk("abort_no_done", NL'(saw), '0);
        run8(8'd13, 8'd9, 8'd3, 1'b0, 17, 16, 1'b0, "n13_after_abort");

        // Randomized traffic on the 8-bit instance, checked by the model.
        repeat (3000) begin
            @(negedge clk);
            start8 = ($urandom_range(0, 3) == 0);
            n8     = ($urandom_range(0, 7) == 0) ? NS'($urandom_range(0, 1)) : NS'($urandom);
            rst8   = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        start8 = 1'b0;
        rst8   = 1'b0;
        repeat (20) @(negedge clk);

        // Full-width runs.
        for (int unsigned i = 0; i < NL / 32; i++) nv[i*32 +: 32] = $urandom;
        nv[NL-1] = 1'b1;
        nv[0]    = 1'b1;
        runl(nv, 1'b0, '0, 1'b1, "wide_random");
        runl('1, 1'b1, NL'(1), 1'b0, "wide_all_ones");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
